ace_snapshot_loader: RTL and testbench

//  Sequences a host byte stream of a compressed .ace snapshot into the Ace memory map over the

---
 rtl/ace_snapshot_loader_if.sv | 20 ++
 rtl/ace_snapshot_loader.sv | 190 +++++++++++++++++++
 tb/tb_ace_snapshot_loader.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ace_snapshot_loader_if.sv
// Host byte-stream handshake plus the loader write port of the Jupiter Ace memory map.
interface ace_snapshot_loader_if;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        loader_en;
  logic [15:0] loader_addr;
  logic [7:0]  loader_data;
  logic        loader_wr;

  modport master (
    output s_data, s_valid,
    input  s_ready, loader_en, loader_addr, loader_data, loader_wr
  );

  modport slave (
    input  s_data, s_valid,
    output s_ready, loader_en, loader_addr, loader_data, loader_wr
  );
endinterface

// File: rtl/ace_snapshot_loader.sv
// Expands an RLE-compressed .ace snapshot stream into one loader write per byte from BASE_ADDR up,
// holding the machine in loader mode until the end marker (ESC 00) or an address overflow.
module ace_snapshot_loader #(
  parameter logic [15:0] BASE_ADDR  = 16'h2000,
  parameter logic [15:0] LIMIT_ADDR = 16'hFFFF,
  parameter logic [7:0]  ESC        = 8'hED
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  ace_snapshot_loader_if.slave        bus,
  output logic                        busy,
  output logic                        done,
  output logic                        error
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_ESC_CNT = 3'd2,
    ST_ESC_VAL = 3'd3,
    ST_RUN     = 3'd4,
    ST_DONE    = 3'd5,
    ST_ERR     = 3'd6
  } state_t;

  state_t      state_r, state_s;
  logic [16:0] addr_r, addr_s;
  logic [7:0]  run_cnt_r, run_cnt_s;
  logic [7:0]  run_val_r, run_val_s;
  logic        en_r, en_s;
  logic        wr_r, wr_s;
  logic [15:0] waddr_r, waddr_s;
  logic [7:0]  wdata_r, wdata_s;
  logic        ready_r, ready_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        error_r, error_s;
  logic        accept_s;
  logic        overflow_s;

  assign accept_s   = bus.s_valid & ready_r;
  // 17-bit compare also catches the wrap past 16'hFFFF
  assign overflow_s = (addr_r > {1'b0, LIMIT_ADDR});

  assign bus.s_ready     = ready_r;
  assign bus.loader_en   = en_r;
  assign bus.loader_addr = waddr_r;
  assign bus.loader_data = wdata_r;
  assign bus.loader_wr   = wr_r;
  assign busy            = busy_r;
  assign done            = done_r;
  assign error           = error_r;

  // Next-state, counters and registered-output values.
  always_comb begin
    state_s   = state_r;
    addr_s    = addr_r;
    run_cnt_s = run_cnt_r;
    run_val_s = run_val_r;
    en_s      = en_r;
    wr_s      = 1'b0;
    waddr_s   = waddr_r;
    wdata_s   = wdata_r;
    busy_s    = busy_r;
    done_s    = done_r;
    error_s   = error_r;
    ready_s   = 1'b0;

    case (state_r)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_s   = ST_FETCH;
          addr_s    = {1'b0, BASE_ADDR};
          run_cnt_s = 8'd0;
          done_s    = 1'b0;
          error_s   = 1'b0;
          en_s      = 1'b1;
          busy_s    = 1'b1;
        end else begin
          // DONE keeps loader_en for exactly the one cycle after the end marker
          en_s = 1'b0;
        end
      end
      ST_FETCH: begin
        if (accept_s) begin
          if (bus.s_data == ESC) begin
            state_s = ST_ESC_CNT;
          end else if (overflow_s) begin
            state_s = ST_ERR;
            en_s    = 1'b0;
            busy_s  = 1'b0;
            error_s = 1'b1;
          end else begin
            wr_s    = 1'b1;
            waddr_s = addr_r[15:0];
            wdata_s = bus.s_data;
            addr_s  = addr_r + 17'd1;
          end
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_ESC_CNT: begin
        if (accept_s) begin
          if (bus.s_data == 8'd0) begin
            state_s = ST_DONE;
            busy_s  = 1'b0;
            done_s  = 1'b1;
          end else begin
            run_cnt_s = bus.s_data;
            state_s   = ST_ESC_VAL;
          end
        end else begin
          state_s = ST_ESC_CNT;
        end
      end
      ST_ESC_VAL: begin
        if (accept_s) begin
          run_val_s = bus.s_data;
          state_s   = ST_RUN;
        end else begin
          state_s = ST_ESC_VAL;
        end
      end
      ST_RUN: begin
        if (overflow_s) begin
          state_s = ST_ERR;
          en_s    = 1'b0;
          busy_s  = 1'b0;
          error_s = 1'b1;
        end else begin
          wr_s      = 1'b1;
          waddr_s   = addr_r[15:0];
          wdata_s   = run_val_r;
          addr_s    = addr_r + 17'd1;
          run_cnt_s = run_cnt_r - 8'd1;
          if (run_cnt_r == 8'd1) begin
            state_s = ST_FETCH;
          end else begin
            state_s = ST_RUN;
          end
        end
      end
      default: begin
        state_s = ST_IDLE;
        en_s    = 1'b0;
        busy_s  = 1'b0;
      end
    endcase

    if (((state_s == ST_FETCH) || (state_s == ST_ESC_CNT) || (state_s == ST_ESC_VAL)) && !wr_s) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      addr_r    <= {1'b0, BASE_ADDR};
      run_cnt_r <= 8'd0;
      run_val_r <= 8'd0;
      en_r      <= 1'b0;
      wr_r      <= 1'b0;
      waddr_r   <= 16'd0;
      wdata_r   <= 8'd0;
      ready_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      error_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      addr_r    <= addr_s;
      run_cnt_r <= run_cnt_s;
      run_val_r <= run_val_s;
      en_r      <= en_s;
      wr_r      <= wr_s;
      waddr_r   <= waddr_s;
      wdata_r   <= wdata_s;
      ready_r   <= ready_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      error_r   <= error_s;
    end
  end

endmodule

// File: tb/tb_ace_snapshot_loader.sv
// Scoreboard bench for ace_snapshot_loader: directed streams, expected writes queued, monitors compare.
`timescale 1ns/1ps
module tb_ace_snapshot_loader;
  logic clk = 1'b0;
  logic reset;
  logic start_a, start_b;
  logic busy_a, done_a, error_a;
  logic busy_b, done_b, error_b;
  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;
  logic [23:0] q_a[$];
  logic [23:0] q_b[$];
  int   wc_a[$];

  ace_snapshot_loader_if bus_a();
  ace_snapshot_loader_if bus_b();

  ace_snapshot_loader dut_a (
    .clk(clk), .reset(reset), .start(start_a), .bus(bus_a.slave),
    .busy(busy_a), .done(done_a), .error(error_a)
  );

  ace_snapshot_loader #(.LIMIT_ADDR(16'h2001)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .bus(bus_b.slave),
    .busy(busy_b), .done(done_b), .error(error_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor A: every strobe must match the head of the expected-write queue.
  always @(negedge clk) begin
    if (bus_a.loader_wr === 1'b1) begin
      checks++;
      if (q_a.size() == 0) begin
        failures++;
        $display("FAIL wr_a_unexpected actual=%h:%h expected=none", bus_a.loader_addr, bus_a.loader_data);
      end else begin
        logic [23:0] e;
        e = q_a.pop_front();
        if ({bus_a.loader_addr, bus_a.loader_data} !== e) begin
          failures++;
          $display("FAIL wr_a actual=%h:%h expected=%h:%h", bus_a.loader_addr, bus_a.loader_data, e[23:8], e[7:0]);
        end
      end
      checks++;
      if (bus_a.loader_en !== 1'b1 || bus_a.s_ready !== 1'b0) begin
        failures++;
        $display("FAIL wr_a_qual actual=en%b/rdy%b expected=en1/rdy0", bus_a.loader_en, bus_a.s_ready);
      end
      wc_a.push_back(cycle);
    end
  end

  // Monitor B: same scoreboard check for the low-limit instance.
  always @(negedge clk) begin
    if (bus_b.loader_wr === 1'b1) begin
      checks++;
      if (q_b.size() == 0) begin
        failures++;
        $display("FAIL wr_b_unexpected actual=%h:%h expected=none", bus_b.loader_addr, bus_b.loader_data);
      end else begin
        logic [23:0] e;
        e = q_b.pop_front();
        if ({bus_b.loader_addr, bus_b.loader_data} !== e) begin
          failures++;
          $display("FAIL wr_b actual=%h:%h expected=%h:%h", bus_b.loader_addr, bus_b.loader_data, e[23:8], e[7:0]);
        end
      end
    end
  end

  task automatic pulse_start(input bit sel);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic send(input bit sel, input logic [7:0] b, input int gap);
    bit ok;
    ok = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    if (sel) begin bus_b.s_data = b; bus_b.s_valid = 1'b1; end
    else     begin bus_a.s_data = b; bus_a.s_valid = 1'b1; end
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if ((sel ? bus_b.s_ready : bus_a.s_ready) === 1'b1) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end
    end
    bus_a.s_valid = 1'b0;
    bus_b.s_valid = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_accepted expected=accepted byte=%h", b);
    end
  endtask

  task automatic wait_end(input bit sel);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (sel ? (done_b | error_b) : (done_a | error_a)) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL end_timeout actual=busy expected=done_or_error");
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
    bus_a.s_valid = 1'b0; bus_a.s_data = 8'h00;
    bus_b.s_valid = 1'b0; bus_b.s_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_en",    {31'd0, bus_a.loader_en}, 32'd0);
    check("rst_wr",    {31'd0, bus_a.loader_wr}, 32'd0);
    check("rst_flags", {29'd0, busy_a, done_a, error_a}, 32'd0);
    check("rst_ready", {31'd0, bus_a.s_ready}, 32'd0);
    check("rst_addr",  {16'd0, bus_a.loader_addr}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Literals then end marker
    pulse_start(1'b0);
    check("t1_busy", {31'd0, busy_a}, 32'd1);
    q_a.push_back({16'h2000, 8'h41});
    q_a.push_back({16'h2001, 8'h42});
    send(1'b0, 8'h41, 0);
    send(1'b0, 8'h42, 0);
    send(1'b0, 8'hED, 0);
    send(1'b0, 8'h00, 0);
    check("t1_done",    {30'd0, done_a, busy_a}, 32'd2);
    check("t1_en_hold", {31'd0, bus_a.loader_en}, 32'd1);
    @(posedge clk); #1;
    check("t1_en_drop", {31'd0, bus_a.loader_en}, 32'd0);
    check("t1_last_addr", {16'd0, bus_a.loader_addr}, 32'h2001);
    check("t1_q_empty", q_a.size(), 32'd0);

    // Run of three
    pulse_start(1'b0);
    wc_a.delete();
    for (int i = 0; i < 3; i++) q_a.push_back({16'h2000 + 16'(i), 8'h55});
    send(1'b0, 8'hED, 0);
    send(1'b0, 8'h03, 0);
    send(1'b0, 8'h55, 0);
    repeat (4) begin @(posedge clk); #1; end
    check("t2_nwr", wc_a.size(), 32'd3);
    if (wc_a.size() == 3) check("t2_consec", wc_a[2] - wc_a[0], 32'd2);
    send(1'b0, 8'hED, 0);
    send(1'b0, 8'h00, 0);
    wait_end(1'b0);
    check("t2_done", {30'd0, done_a, error_a}, 32'd2);
    check("t2_q_empty", q_a.size(), 32'd0);

    // s_valid toggling every other cycle
    pulse_start(1'b0);
    q_a.push_back({16'h2000, 8'h41});
    q_a.push_back({16'h2001, 8'h42});
    q_a.push_back({16'h2002, 8'h66});
    q_a.push_back({16'h2003, 8'h66});
    send(1'b0, 8'h41, 1);
    send(1'b0, 8'h42, 1);
    send(1'b0, 8'hED, 1);
    send(1'b0, 8'h02, 1);
    send(1'b0, 8'h66, 1);
    send(1'b0, 8'hED, 1);
    send(1'b0, 8'h00, 1);
    wait_end(1'b0);
    check("t3_done", {30'd0, done_a, error_a}, 32'd2);
    check("t3_q_empty", q_a.size(), 32'd0);

    // Overflow past LIMIT_ADDR=2001
    pulse_start(1'b1);
    q_b.push_back({16'h2000, 8'hAA});
    q_b.push_back({16'h2001, 8'hAA});
    send(1'b1, 8'hED, 0);
    send(1'b1, 8'h04, 0);
    send(1'b1, 8'hAA, 0);
    wait_end(1'b1);
    check("t4_flags", {28'd0, error_b, done_b, busy_b, bus_b.loader_en}, 32'h8);
    bus_b.s_data = 8'h11;
    bus_b.s_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("t4_no_ready", {31'd0, bus_b.s_ready}, 32'd0);
    @(posedge clk); #1;
    bus_b.s_valid = 1'b0;
    check("t4_q_empty", q_b.size(), 32'd0);

    // Reset in the middle of a run
    pulse_start(1'b0);
    q_a.push_back({16'h2000, 8'h77});
    send(1'b0, 8'hED, 0);
    send(1'b0, 8'h08, 0);
    send(1'b0, 8'h77, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("t5_rst_out", {29'd0, bus_a.loader_en, bus_a.loader_wr, busy_a}, 32'd0);
    reset = 1'b0;
    check("t5_q_empty", q_a.size(), 32'd0);
    pulse_start(1'b0);
    q_a.push_back({16'h2000, 8'h12});
    send(1'b0, 8'h12, 0);
    send(1'b0, 8'hED, 0);
    send(1'b0, 8'h00, 0);
    wait_end(1'b0);
    check("t5_restart", {30'd0, done_a, error_a}, 32'd2);
    check("t5_q_empty2", q_a.size(), 32'd0);

    // start while busy is ignored
    pulse_start(1'b0);
    q_a.push_back({16'h2000, 8'h10});
    q_a.push_back({16'h2001, 8'h20});
    send(1'b0, 8'h10, 0);
    pulse_start(1'b0);
    send(1'b0, 8'h20, 0);
    send(1'b0, 8'hED, 0);
    send(1'b0, 8'h00, 0);
    wait_end(1'b0);
    check("t6_done", {30'd0, done_a, error_a}, 32'd2);
    check("t6_last_addr", {16'd0, bus_a.loader_addr}, 32'h2001);
    check("t6_q_empty", q_a.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
